// File: rtl/switch_debouncer.sv
// Per-channel switch debouncer: two-flop synchronizer, stability counter and registered
// edge pulses, plus a lowest-index event encoder for the downstream arbiter.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 500000,
  localparam int unsigned IdxW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_n,
  output logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] req_rise,
  output logic [WIDTH-1:0] req_fall,
  output logic             evt_valid,
  output logic [IdxW-1:0]  evt_idx
);

  localparam int unsigned     CntW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sync_req;

  // Sync stages preset to 1 so reset looks like "all switches released".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_n;
      sync2_q <= sync1_q;
    end
  end

  assign sync_req = ~sync2_q;

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           req_q, req_d;
  logic [WIDTH-1:0]           rise_q, rise_d;
  logic [WIDTH-1:0]           fall_q, fall_d;

  // Counter clears whenever the input agrees with req; it saturates into an acceptance,
  // so it can never wrap.
  always_comb begin
    cnt_d  = '0;
    req_d  = req_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync_req[i] != req_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          req_d[i]  = sync_req[i];
          rise_d[i] = sync_req[i];
          fall_d[i] = ~sync_req[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      req_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign req      = req_q;
  assign req_rise = rise_q;
  assign req_fall = fall_q;

  logic [WIDTH-1:0] evt;

  // Scan from the top so the lowest pulsing channel is the last to write evt_idx.
  always_comb begin
    evt       = rise_q | fall_q;
    evt_valid = |evt;
    evt_idx   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (evt[i]) begin
        evt_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboarded bench for switch_debouncer with WIDTH=8, STABLE_CYCLES=4.
module tb_switch_debouncer;

  localparam int unsigned W = 8;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_n;
  logic [W-1:0] req, req_rise, req_fall;
  logic         evt_valid;
  logic [2:0]   evt_idx;

  switch_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_n      (sw_n),
    .req       (req),
    .req_rise  (req_rise),
    .req_fall  (req_fall),
    .evt_valid (evt_valid),
    .evt_idx   (evt_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] req;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [2:0] idx;
  } evt_t;

  evt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic evt_t mk_evt(input int c, input logic [7:0] r, input logic [7:0] ri,
                                  input logic [7:0] fa, input logic [2:0] ix);
    evt_t e;
    e.cyc  = c;
    e.req  = r;
    e.rise = ri;
    e.fall = fa;
    e.idx  = ix;
    return e;
  endfunction

  // Every pulse must match the next expected event, in the expected cycle.
  always @(negedge clk) begin
    evt_t e;
    if ((req_rise | req_fall) !== 8'h00 || evt_valid !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc %0d rise %h fall %h valid %b, expected no pulse",
                 cyc, req_rise, req_fall, evt_valid);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || req !== e.req || req_rise !== e.rise || req_fall !== e.fall ||
            evt_valid !== 1'b1 || evt_idx !== e.idx) begin
          errors++;
          $display("FAIL event: got cyc %0d req %h rise %h fall %h valid %b idx %0d, expected cyc %0d req %h rise %h fall %h valid 1 idx %0d",
                   cyc, req, req_rise, req_fall, evt_valid, evt_idx,
                   e.cyc, e.req, e.rise, e.fall, e.idx);
        end
      end
    end else begin
      checks++;
      if (evt_idx !== 3'd0) begin
        errors++;
        $display("FAIL idle_idx: got %0d, expected 0", evt_idx);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    sw_n = 8'hFF;
    #1;
    checks++;
    if (req !== 8'h00 || req_rise !== 8'h00 || req_fall !== 8'h00 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: req %h rise %h fall %h valid %b, expected all 0",
               req, req_rise, req_fall, evt_valid);
    end
    tick(3);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: req %h, expected 00", req);
    end
    rst = 1'b1;
    tick(10);
    checks++;
    if (req !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: req %h pending %0d, expected 00 and 0", req, sb.size());
    end
  endtask

  task automatic test_single_press;
    int n;
    n    = cyc;
    sw_n = 8'hFE;
    sb.push_back(mk_evt(n + 6, 8'h01, 8'h01, 8'h00, 3'd0));
    tick(5);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL press_early: req %h, expected 00", req);
    end
    tick(1);
    checks++;
    if (req !== 8'h01 || req_rise !== 8'h01 || evt_valid !== 1'b1 || evt_idx !== 3'd0) begin
      errors++;
      $display("FAIL press_accept: req %h rise %h valid %b idx %0d, expected 01 01 1 0",
               req, req_rise, evt_valid, evt_idx);
    end
    tick(1);
    checks++;
    if (req !== 8'h01 || req_rise !== 8'h00 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL press_one_cycle: req %h rise %h valid %b, expected 01 00 0",
               req, req_rise, evt_valid);
    end
  endtask

  task automatic test_swap;
    int n;
    n    = cyc;
    sw_n = 8'h7F;
    sb.push_back(mk_evt(n + 6, 8'h80, 8'h80, 8'h01, 3'd0));
    tick(5);
    checks++;
    if (req !== 8'h01) begin
      errors++;
      $display("FAIL swap_early: req %h, expected 01", req);
    end
    tick(1);
    checks++;
    if (req !== 8'h80 || req_rise !== 8'h80 || req_fall !== 8'h01) begin
      errors++;
      $display("FAIL swap_accept: req %h rise %h fall %h, expected 80 80 01",
               req, req_rise, req_fall);
    end
    tick(2);
    n    = cyc;
    sw_n = 8'hFF;
    sb.push_back(mk_evt(n + 6, 8'h00, 8'h00, 8'h80, 3'd7));
    tick(8);
    checks++;
    if (req !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL release_high: req %h pending %0d, expected 00 and 0", req, sb.size());
    end
  endtask

  task automatic test_glitch;
    int n;
    sw_n = 8'hF7;
    tick(3);
    sw_n = 8'hFF;
    tick(8);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL glitch_ignored: req %h, expected 00", req);
    end
    // A fresh press must take the full count, proving the glitch left no residue.
    n    = cyc;
    sw_n = 8'hF7;
    sb.push_back(mk_evt(n + 6, 8'h08, 8'h08, 8'h00, 3'd3));
    tick(5);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL glitch_fresh_early: req %h, expected 00", req);
    end
    tick(1);
    checks++;
    if (req !== 8'h08) begin
      errors++;
      $display("FAIL glitch_fresh_accept: req %h, expected 08", req);
    end
    n    = cyc;
    sw_n = 8'hFF;
    sb.push_back(mk_evt(n + 6, 8'h00, 8'h00, 8'h08, 3'd3));
    tick(8);
  endtask

  task automatic test_multi;
    int n;
    n    = cyc;
    sw_n = 8'h5A;
    sb.push_back(mk_evt(n + 6, 8'hA5, 8'hA5, 8'h00, 3'd0));
    tick(6);
    checks++;
    if (req !== 8'hA5 || req_rise !== 8'hA5 || evt_idx !== 3'd0) begin
      errors++;
      $display("FAIL multi_accept: req %h rise %h idx %0d, expected A5 A5 0",
               req, req_rise, evt_idx);
    end
    n    = cyc;
    sw_n = 8'hFF;
    sb.push_back(mk_evt(n + 6, 8'h00, 8'h00, 8'hA5, 3'd0));
    tick(8);
    checks++;
    if (req !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL multi_release: req %h pending %0d, expected 00 and 0", req, sb.size());
    end
  endtask

  task automatic test_async_reset;
    int n;
    n    = cyc;
    sw_n = 8'hF0;
    sb.push_back(mk_evt(n + 6, 8'h0F, 8'h0F, 8'h00, 3'd0));
    tick(8);
    checks++;
    if (req !== 8'h0F) begin
      errors++;
      $display("FAIL async_pre: req %h, expected 0F", req);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (req !== 8'h00 || req_rise !== 8'h00 || req_fall !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: req %h rise %h fall %h, expected 00 00 00",
               req, req_rise, req_fall);
    end
    sw_n = 8'hFF;
    tick(3);
    rst = 1'b1;
    tick(10);
    checks++;
    if (req !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL async_after: req %h pending %0d, expected 00 and 0", req, sb.size());
    end
  endtask

  task automatic test_reset_mid_count;
    int m;
    sw_n = 8'hFB;
    tick(4);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (req !== 8'h00 || req_rise !== 8'h00 || req_fall !== 8'h00) begin
        errors++;
        $display("FAIL midreset_hold: req %h rise %h fall %h, expected 00 00 00",
                 req, req_rise, req_fall);
      end
    end
    m   = cyc;
    rst = 1'b1;
    sb.push_back(mk_evt(m + 6, 8'h04, 8'h04, 8'h00, 3'd2));
    tick(5);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL midreset_early: req %h, expected 00", req);
    end
    tick(1);
    checks++;
    if (req !== 8'h04) begin
      errors++;
      $display("FAIL midreset_accept: req %h, expected 04", req);
    end
    m    = cyc;
    sw_n = 8'hFF;
    sb.push_back(mk_evt(m + 6, 8'h00, 8'h00, 8'h04, 3'd2));
    tick(8);
  endtask

  task automatic test_toggle;
    for (int k = 0; k < 20; k++) begin
      sw_n = (k % 2 == 0) ? 8'hDF : 8'hFF;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        checks++;
        if (req !== 8'h00) begin
          errors++;
          $display("FAIL toggle_stable: req %h, expected 00", req);
        end
      end
    end
    sw_n = 8'hFF;
    tick(6);
    checks++;
    if (req !== 8'h00 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_end: req %h pending %0d, expected 00 and 0", req, sb.size());
    end
  endtask

  task automatic test_pressed_at_reset;
    int m;
    rst  = 1'b0;
    sw_n = 8'hFD;
    tick(2);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL poweron_hold: req %h, expected 00", req);
    end
    m   = cyc;
    rst = 1'b1;
    sb.push_back(mk_evt(m + 6, 8'h02, 8'h02, 8'h00, 3'd1));
    tick(5);
    checks++;
    if (req !== 8'h00) begin
      errors++;
      $display("FAIL poweron_early: req %h, expected 00", req);
    end
    tick(1);
    checks++;
    if (req !== 8'h02 || req_rise !== 8'h02 || evt_idx !== 3'd1) begin
      errors++;
      $display("FAIL poweron_accept: req %h rise %h idx %0d, expected 02 02 1",
               req, req_rise, evt_idx);
    end
    m    = cyc;
    sw_n = 8'hFF;
    sb.push_back(mk_evt(m + 6, 8'h00, 8'h00, 8'h02, 3'd1));
    tick(8);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_swap();
    test_glitch();
    test_multi();
    test_async_reset();
    test_reset_mid_count();
    test_toggle();
    test_pressed_at_reset();
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 8: number of switch channels; legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 500000: consecutive cycles a new level must hold before acceptance; legal minimum 2.
REQ-003 Port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1  reset; one clock, asynchronous, active-low.
REQ-005 Port sw_n  input  WIDTH  raw switch levels, asynchronous to clk, active-low (0 = switch on).
REQ-006 Port req  output  WIDTH  debounced request vector, active-high; feeds the arbiter request input directly.
REQ-007 Port req_rise  output  WIDTH  one-cycle pulse per channel when req bit goes 0->1.
REQ-008 Port req_fall  output  WIDTH  one-cycle pulse per channel when req bit goes 1->0.
REQ-009 Port evt_valid  output  1  high in any cycle where some req_rise or req_fall bit is high.
REQ-010 Port evt_idx  output  clog2(WIDTH), minimum 1  index of the lowest-numbered channel with a pulse in that cycle; 0 when evt_valid is low.

Function
REQ-011 Each sw_n bit SHALL pass through its own two-flop synchronizer; the second-stage output is inverted to give sync_req[i].
REQ-012 Each channel SHALL own a counter of width clog2(STABLE_CYCLES), minimum 1.
REQ-013 When sync_req[i] == req[i], counter[i] SHALL load 0 on the next edge.
REQ-014 When sync_req[i] != req[i] and counter[i] < STABLE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 When sync_req[i] != req[i] and counter[i] == STABLE_CYCLES-1, req[i] SHALL load sync_req[i] and counter[i] SHALL load 0 on the same edge.
REQ-016 A glitch shorter than STABLE_CYCLES sync cycles SHALL clear the counter and leave req unchanged; the counter never wraps.
REQ-017 Latency: with edge 0 defined as the first clk edge sampling a new stable sw_n level, req SHALL change on edge STABLE_CYCLES+1.
REQ-018 req_rise[i] and req_fall[i] SHALL be registered and high exactly in the cycle req[i] first shows its new value, low otherwise.
REQ-019 Channels SHALL be fully independent; simultaneous acceptances on several channels SHALL produce simultaneous pulses.
REQ-020 evt_valid and evt_idx SHALL be combinational from req_rise | req_fall, with lowest index winning on ties.
REQ-021 No req bit SHALL change more than once per STABLE_CYCLES cycles.

Reset
REQ-022 While rst is low, synchronizer flops SHALL hold 1 (switch released), and req, req_rise, req_fall and all counters SHALL hold 0, independent of clk.
REQ-023 Assertion of rst mid-count SHALL discard the partial count; after release every channel restarts its debounce from counter 0.
REQ-024 After rst deasserts with all sw_n high, outputs SHALL stay 0 with no spurious pulses.
REQ-025 After rst deasserts with sw_n[i] already low, req[i] SHALL rise on edge STABLE_CYCLES+1 after the first sampling edge (with the two-flop sync stages preset to 1), with one req_rise[i] pulse.

Verification (STABLE_CYCLES=4, WIDTH=8)
REQ-026 sw_n 0xFF->0xFE held -> req=0x01 on edge 5 after first sampling edge; req_rise=0x01, evt_valid=1 and evt_idx=0 for one cycle.
REQ-027 sw_n bit 3 low for 3 sync cycles then high again -> req stays 0x00, no pulses, counter[3] back to 0.
REQ-028 sw_n 0xFF->0x5A in one cycle, held -> req=0xA5 on one edge; req_rise=0xA5, evt_idx=0, evt_valid=1 for one cycle.
REQ-029 req=0x01, then sw_n bit 0 released while bit 7 pressed in the same cycle -> req=0x80 on edge 5 after first sampling edge; req_fall=0x01, req_rise=0x80, evt_idx=0.
REQ-030 sw_n bit 2 low, rst pulsed low after 2 counted cycles -> during reset req=0 and no pulses; after release req[2] rises only after a full fresh 4-cycle count.
REQ-031 sw_n toggled every 2 cycles on bit 5 for 40 cycles -> req[5] never changes; at all times req_rise|req_fall pulses last one cycle only.
